// File: rtl/hdmi_rx_pkg.sv
// hdmi_rx_pkg
//   Shared definitions for the HDMI TMDS receive decoder: the four control
//   codes, video/data guard-band symbols, the TERC4 code table, the decoder
//   FSM state type and the per-triple symbol classification type.
package hdmi_rx_pkg;

  localparam logic [9:0] CTL_CODE_00 = 10'b1101010100;
  localparam logic [9:0] CTL_CODE_01 = 10'b0010101011;
  localparam logic [9:0] CTL_CODE_10 = 10'b0101010100;
  localparam logic [9:0] CTL_CODE_11 = 10'b1010101011;

  localparam logic [9:0] VGUARD_RED = 10'b1011001100;
  localparam logic [9:0] VGUARD_GRN = 10'b0100110011;
  localparam logic [9:0] VGUARD_BLU = 10'b1011001100;
  localparam logic [9:0] DGUARD_RG  = 10'b0100110011;

  // Index is the 4-bit nibble carried by the code.
  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef enum logic [2:0] {
    ST_CTRL,
    ST_VGUARD,
    ST_VIDEO,
    ST_DGUARD_L,
    ST_ISLAND,
    ST_DGUARD_T
  } rx_state_t;

  typedef enum logic [2:0] {
    SC_CTRL,
    SC_TERC4,
    SC_DATA,
    SC_GUARD,
    SC_ILLEGAL
  } sym_class_t;

endpackage

// File: rtl/tmds_decode_ch.sv
// tmds_decode_ch
//   Combinational decode of one 10-bit TMDS channel symbol, in all three
//   interpretations at once; the caller picks the one the link state needs.
//   Ports:
//     sym      in   10-bit received symbol
//     is_ctrl  out  symbol is one of the four control codes
//     ctl      out  2-bit control value (valid when is_ctrl)
//     is_terc  out  symbol is a TERC4 code
//     terc     out  4-bit TERC4 nibble (valid when is_terc)
//     data     out  8-bit TMDS video-data decode (always computed)
module tmds_decode_ch
  import hdmi_rx_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_ctrl,
  output logic [1:0] ctl,
  output logic       is_terc,
  output logic [3:0] terc,
  output logic [7:0] data
);

  logic [7:0] q;

  always_comb begin
    is_ctrl = 1'b0;
    ctl     = '0;
    case (sym)
      CTL_CODE_00: begin is_ctrl = 1'b1; ctl = 2'b00; end
      CTL_CODE_01: begin is_ctrl = 1'b1; ctl = 2'b01; end
      CTL_CODE_10: begin is_ctrl = 1'b1; ctl = 2'b10; end
      CTL_CODE_11: begin is_ctrl = 1'b1; ctl = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    is_terc = 1'b0;
    terc    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (sym == TERC4_CODE[i]) begin
        is_terc = 1'b1;
        terc    = 4'(i);
      end
    end
  end

  // bit9 marks an inverted payload; bit8 selects XOR (1) or XNOR (0) chaining.
  always_comb begin
    q       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = '0;
    data[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/hdmi_rx_decoder.sv
// hdmi_rx_decoder
//   TMDS receive decoder. Classifies each {red, green, blue} symbol triple,
//   tracks the HDMI period sequence (control, preamble, guard, video or data
//   island) and recovers the {R, G, B, DE, HSYNC, VSYNC} word plus TERC4
//   island nibbles. Latency from d to all outputs is 2 clk.
//   Optional error counter: define HDMI_RX_ERRCNT_EN to build err_count as a
//   saturating count of sym_err pulses; otherwise err_count is tied to 0.
//   Ports:
//     clk           in   pixel clock
//     rst           in   synchronous active-high reset
//     d             in   30-bit TMDS triple {red, green, blue}
//     dd            out  27-bit {R, G, B, DE, HSYNC, VSYNC}
//     island_valid  out  decoded data-island symbol this cycle
//     island_data   out  TERC4 nibbles {red, green, blue}
//     locked        out  video period decoded since last error/reset
//     sym_err       out  one-cycle pulse on illegal/out-of-sequence symbol
//     err_count     out  saturating error count (0 when feature disabled)
module hdmi_rx_decoder
  import hdmi_rx_pkg::*;
#(
  parameter int unsigned ISLAND_LEN = 32,
  parameter int unsigned PRE_MIN    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] d,
  output logic [26:0] dd,
  output logic        island_valid,
  output logic [11:0] island_data,
  output logic        locked,
  output logic        sym_err,
  output logic [15:0] err_count
);

  localparam int unsigned    ICW       = (ISLAND_LEN > 1) ? $clog2(ISLAND_LEN) : 1;
  localparam logic [ICW-1:0] ISL_LAST  = ICW'(ISLAND_LEN - 1);
  localparam logic [3:0]     PRE_MIN_C = (PRE_MIN > 15) ? 4'hF : 4'(PRE_MIN);

  // Stage 1: input register; d_vld keeps post-reset garbage out of stage 2.
  logic [29:0] d_q;
  logic        d_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      d_vld <= 1'b0;
    end else begin
      d_q   <= d;
      d_vld <= 1'b1;
    end
  end

  logic       r_is_ctrl, g_is_ctrl, b_is_ctrl;
  logic [1:0] r_ctl, g_ctl, b_ctl;
  logic       r_is_terc, g_is_terc, b_is_terc;
  logic [3:0] r_terc, g_terc, b_terc;
  logic [7:0] r_data, g_data, b_data;

  tmds_decode_ch u_dec_red (
    .sym(d_q[29:20]), .is_ctrl(r_is_ctrl), .ctl(r_ctl),
    .is_terc(r_is_terc), .terc(r_terc), .data(r_data)
  );
  tmds_decode_ch u_dec_grn (
    .sym(d_q[19:10]), .is_ctrl(g_is_ctrl), .ctl(g_ctl),
    .is_terc(g_is_terc), .terc(g_terc), .data(g_data)
  );
  tmds_decode_ch u_dec_blu (
    .sym(d_q[9:0]), .is_ctrl(b_is_ctrl), .ctl(b_ctl),
    .is_terc(b_is_terc), .terc(b_terc), .data(b_data)
  );

  rx_state_t      state;
  logic [3:0]     pre_cnt;
  logic           pre_is_data;
  logic [1:0]     hv_last;       // {HSYNC, VSYNC}
  logic [ICW-1:0] isl_cnt;
  logic           g_second;

  sym_class_t sclass;
  logic       is_vguard, is_dguard, is_vpre, is_dpre;
  logic       guard_ok_v, guard_ok_d;
  logic [3:0] pre_cnt_ctl;
  logic [1:0] ctl_hv, terc_hv;
  logic       ctrl_sym, err_now;

  always_comb begin
    is_vguard = (d_q == {VGUARD_RED, VGUARD_GRN, VGUARD_BLU});
    is_dguard = (d_q[29:20] == DGUARD_RG) && (d_q[19:10] == DGUARD_RG) &&
                b_is_terc && (b_terc[3:2] == 2'b11);
    if (r_is_ctrl && g_is_ctrl && b_is_ctrl)      sclass = SC_CTRL;
    else if (is_vguard || is_dguard)              sclass = SC_GUARD;
    else if (r_is_terc && g_is_terc && b_is_terc) sclass = SC_TERC4;
    else if (r_is_ctrl || g_is_ctrl || b_is_ctrl) sclass = SC_ILLEGAL;
    else                                          sclass = SC_DATA;
    is_vpre = (sclass == SC_CTRL) && (r_ctl == 2'b00) && (g_ctl == 2'b01);
    is_dpre = (sclass == SC_CTRL) && (r_ctl == 2'b01) && (g_ctl == 2'b01);
    ctl_hv  = {b_ctl[0], b_ctl[1]};
    terc_hv = {b_terc[0], b_terc[1]};
  end

  // Preamble run length: restarts on a type change, clears on plain control.
  always_comb begin
    pre_cnt_ctl = '0;
    if (is_vpre || is_dpre) begin
      if ((pre_cnt != 4'd0) && (pre_is_data == is_dpre))
        pre_cnt_ctl = (pre_cnt == 4'hF) ? pre_cnt : pre_cnt + 4'd1;
      else
        pre_cnt_ctl = 4'd1;
    end
  end

  always_comb begin
    guard_ok_v = is_vguard && !pre_is_data && (pre_cnt >= PRE_MIN_C);
    guard_ok_d = is_dguard &&  pre_is_data && (pre_cnt >= PRE_MIN_C);
    ctrl_sym   = (sclass == SC_CTRL) && ((state == ST_CTRL) || (state == ST_VIDEO));
    err_now    = 1'b0;
    case (state)
      ST_CTRL:     err_now = (sclass != SC_CTRL) && !guard_ok_v && !guard_ok_d;
      ST_VGUARD:   err_now = !is_vguard;
      ST_VIDEO:    err_now = (sclass == SC_ILLEGAL);
      ST_DGUARD_L: err_now = !is_dguard;
      ST_ISLAND:   err_now = (sclass != SC_TERC4);
      ST_DGUARD_T: err_now = !is_dguard;
      default:     err_now = 1'b1;
    endcase
    err_now = err_now && d_vld;
  end

  // Stage 2: sequence FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_CTRL;
      pre_cnt      <= '0;
      pre_is_data  <= 1'b0;
      hv_last      <= '0;
      isl_cnt      <= '0;
      g_second     <= 1'b0;
      dd           <= '0;
      island_valid <= 1'b0;
      island_data  <= '0;
      locked       <= 1'b0;
      sym_err      <= 1'b0;
    end else begin
      sym_err      <= err_now;
      island_valid <= 1'b0;
      if (err_now) begin
        state   <= ST_CTRL;
        pre_cnt <= '0;
        locked  <= 1'b0;
        dd      <= {25'h0, hv_last};
      end else if (d_vld) begin
        if (ctrl_sym) begin
          // A control triple ends video and is handled as control this cycle.
          state       <= ST_CTRL;
          pre_cnt     <= pre_cnt_ctl;
          pre_is_data <= is_dpre;
          hv_last     <= ctl_hv;
          dd          <= {25'h0, ctl_hv};
        end else begin
          case (state)
            ST_CTRL: begin
              pre_cnt <= '0;
              if (guard_ok_v) begin
                state <= ST_VGUARD;
                dd    <= {25'h0, hv_last};
              end else begin
                state   <= ST_DGUARD_L;
                hv_last <= terc_hv;
                dd      <= {25'h0, terc_hv};
              end
            end
            ST_VGUARD: begin
              state <= ST_VIDEO;
              dd    <= {25'h0, hv_last};
            end
            ST_VIDEO: begin
              dd     <= {r_data, g_data, b_data, 1'b1, hv_last};
              locked <= 1'b1;
            end
            ST_DGUARD_L: begin
              state   <= ST_ISLAND;
              isl_cnt <= '0;
              hv_last <= terc_hv;
              dd      <= {25'h0, terc_hv};
            end
            ST_ISLAND: begin
              island_valid <= 1'b1;
              island_data  <= {r_terc, g_terc, b_terc};
              hv_last      <= terc_hv;
              dd           <= {25'h0, terc_hv};
              if (isl_cnt == ISL_LAST) begin
                state    <= ST_DGUARD_T;
                g_second <= 1'b0;
              end else begin
                isl_cnt <= isl_cnt + ICW'(1);
              end
            end
            ST_DGUARD_T: begin
              hv_last  <= terc_hv;
              dd       <= {25'h0, terc_hv};
              g_second <= 1'b1;
              if (g_second) state <= ST_CTRL;
            end
            default: state <= ST_CTRL;
          endcase
        end
      end
    end
  end

`ifdef HDMI_RX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (err_now && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule
